ss_mult_controller: RTL

SS_MULT_CONTROLLER -- requirements
Module: ss_mult_controller

---
 rtl/ss_mult_controller.sv | 106 ++++++++++
 1 files changed

// File: rtl/ss_mult_controller.sv
// Stochastic multiplier stream controller: it latches the operands, runs two LFSRs for N
// cycles, and accumulates the product symbols. The result is returned with a valid/ready handshake.
module ss_mult_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [1:0]  len_sel,
  input  logic [8:0]  x_in,
  input  logic [8:0]  y_in,
  output logic [8:0]  x_input,
  output logic [8:0]  y_input,
  output logic [7:0]  x_randnum,
  output logic [7:0]  y_randnum,
  input  logic [3:0]  z_ss,
  output logic        busy,
  output logic [11:0] result,
  output logic        result_valid,
  input  logic        result_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] X_SEED = 8'hA5;
  localparam logic [7:0] Y_SEED = 8'h3C;

  state_t      state;
  logic [7:0]  count;
  logic [7:0]  last;
  logic [11:0] acc;
  logic [11:0] acc_nxt;
  logic [7:0]  last_sel;
  logic [7:0]  x_step;
  logic [7:0]  y_step;

  assign acc_nxt = acc + {8'b0, z_ss};
  assign x_step  = {x_randnum[6:0], x_randnum[7] ^ x_randnum[5] ^ x_randnum[4] ^ x_randnum[3]};
  assign y_step  = {y_randnum[6:0], y_randnum[7] ^ y_randnum[3] ^ y_randnum[2] ^ y_randnum[1]};

  // Terminal count is N-1, so the count fits in 8 bits even when N is 256.
  always_comb begin
    last_sel = 8'd31;
    case (len_sel)
      2'b00: last_sel = 8'd31;
      2'b01: last_sel = 8'd63;
      2'b10: last_sel = 8'd127;
      2'b11: last_sel = 8'd255;
      default: last_sel = 8'd31;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      acc          <= '0;
      count        <= '0;
      last         <= 8'd31;
      x_input      <= '0;
      y_input      <= '0;
      x_randnum    <= X_SEED;
      y_randnum    <= Y_SEED;
    end else begin
      case (state)
        IDLE: if (start) begin
          state     <= RUN;
          busy      <= 1'b1;
          x_input   <= x_in;
          y_input   <= y_in;
          last      <= last_sel;
          acc       <= '0;
          count     <= '0;
          x_randnum <= X_SEED;
          y_randnum <= Y_SEED;
        end
        RUN: if (abort) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          acc       <= acc_nxt;
          count     <= count + 8'd1;
          x_randnum <= x_step;
          y_randnum <= y_step;
          // The final sample is folded in on the same edge that enters DONE.
          if (count == last) begin
            state        <= DONE;
            result       <= acc_nxt;
            result_valid <= 1'b1;
          end
        end
        DONE: if (result_ready) begin
          state        <= IDLE;
          busy         <= 1'b0;
          result_valid <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
